// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port
// DataMemory. The arbiter connects through the slave modport. The master
// modport is the environment side: both requesters plus the memory's
// read-data return.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // requester 0 (CPU load/store path)
  logic                  Req0;
  logic                  We0;
  logic [ADDR_WIDTH-1:0] Addr0;
  logic [DATA_WIDTH-1:0] WData0;
  logic                  Ack0;
  logic [DATA_WIDTH-1:0] RData0;

  // requester 1 (debug/DMA loader)
  logic                  Req1;
  logic                  We1;
  logic [ADDR_WIDTH-1:0] Addr1;
  logic [DATA_WIDTH-1:0] WData1;
  logic                  Ack1;
  logic [DATA_WIDTH-1:0] RData1;

  // status
  logic                  Busy;

  // DataMemory side
  logic                  MemWriteEn;
  logic                  MemReadEn;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0] MemWriteData;
  logic [DATA_WIDTH-1:0] MemReadData;

  modport slave (
    input  Req0, We0, Addr0, WData0,
    input  Req1, We1, Addr1, WData1,
    input  MemReadData,
    output Ack0, RData0, Ack1, RData1,
    output Busy,
    output MemWriteEn, MemReadEn, MemAddress, MemWriteData
  );

  modport master (
    output Req0, We0, Addr0, WData0,
    output Req1, We1, Addr1, WData1,
    output MemReadData,
    input  Ack0, RData0, Ack1, RData1,
    input  Busy,
    input  MemWriteEn, MemReadEn, MemAddress, MemWriteData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the single-port
// DataMemory. A granted request is latched into issue registers, driven
// onto the memory for exactly one cycle (SERVE), then acknowledged with a
// registered one-cycle Ack pulse (ACK). All outputs come from flops, so
// there is no combinational path from the requester inputs to the memory.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Round-robin pick. A lone requester always wins. On a tie the requester
  // that did not win last time gets the grant.
  function automatic logic pick_grant(input logic req0,
                                      input logic req1,
                                      input logic last_gnt);
    logic g;
    if (req0 && req1) begin
      g = ~last_gnt;
    end else if (req0) begin
      g = 1'b0;
    end else begin
      g = 1'b1;
    end
    return g;
  endfunction

  // FSM state and fairness history
  state_t                state_r;
  logic                  last_gnt_r;

  // issue registers: these alone drive the memory while a transaction is in flight
  logic                  gnt_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;

  // registered outputs
  logic                  mem_we_r;
  logic                  mem_re_r;
  logic                  ack0_r;
  logic                  ack1_r;
  logic                  busy_r;
  logic [DATA_WIDTH-1:0] rdata0_r;
  logic [DATA_WIDTH-1:0] rdata1_r;

  // arbitration decision, consumed only at the IDLE sampling edge
  logic                  req_any_s;
  logic                  gnt_next_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  // Pick the winner and route its command fields toward the issue registers
  always_comb begin
    req_any_s   = bus.Req0 | bus.Req1;
    gnt_next_s  = pick_grant(bus.Req0, bus.Req1, last_gnt_r);
    sel_we_s    = 1'b0;
    sel_addr_s  = {ADDR_WIDTH{1'b0}};
    sel_wdata_s = {DATA_WIDTH{1'b0}};
    if (gnt_next_s) begin
      sel_we_s    = bus.We1;
      sel_addr_s  = bus.Addr1;
      sel_wdata_s = bus.WData1;
    end else begin
      sel_we_s    = bus.We0;
      sel_addr_s  = bus.Addr0;
      sel_wdata_s = bus.WData0;
    end
  end

  // Sequencer FSM: IDLE grants and latches, SERVE accesses memory, ACK signals completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_gnt_r <= 1'b1;
      gnt_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      wdata_r    <= {DATA_WIDTH{1'b0}};
      mem_we_r   <= 1'b0;
      mem_re_r   <= 1'b0;
      ack0_r     <= 1'b0;
      ack1_r     <= 1'b0;
      busy_r     <= 1'b0;
      rdata0_r   <= {DATA_WIDTH{1'b0}};
      rdata1_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          if (req_any_s) begin
            gnt_r      <= gnt_next_s;
            we_r       <= sel_we_s;
            addr_r     <= sel_addr_s;
            wdata_r    <= sel_wdata_s;
            last_gnt_r <= gnt_next_s;
            // exactly one enable is raised for the single SERVE cycle
            mem_we_r   <= sel_we_s;
            mem_re_r   <= ~sel_we_s;
            busy_r     <= 1'b1;
            state_r    <= SERVE;
          end else begin
            mem_we_r   <= 1'b0;
            mem_re_r   <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end
        end

        SERVE: begin
          // a write commits in DataMemory at this edge; a read is captured
          // here, and only while ReadEn is high, so high-Z is never latched
          if (mem_re_r && !we_r) begin
            if (gnt_r) begin
              rdata1_r <= bus.MemReadData;
            end else begin
              rdata0_r <= bus.MemReadData;
            end
          end
          mem_we_r <= 1'b0;
          mem_re_r <= 1'b0;
          if (gnt_r) begin
            ack1_r <= 1'b1;
          end else begin
            ack0_r <= 1'b1;
          end
          busy_r  <= 1'b1;
          state_r <= ACK;
        end

        ACK: begin
          ack0_r   <= 1'b0;
          ack1_r   <= 1'b0;
          mem_we_r <= 1'b0;
          mem_re_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end

        default: begin
          ack0_r   <= 1'b0;
          ack1_r   <= 1'b0;
          mem_we_r <= 1'b0;
          mem_re_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.Ack0         = ack0_r;
  assign bus.Ack1         = ack1_r;
  assign bus.RData0       = rdata0_r;
  assign bus.RData1       = rdata1_r;
  assign bus.Busy         = busy_r;
  assign bus.MemWriteEn   = mem_we_r;
  assign bus.MemReadEn    = mem_re_r;
  assign bus.MemAddress   = addr_r;
  assign bus.MemWriteData = wdata_r;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port DataMemory.
- Requester 0 is the CPU load/store path; requester 1 is the debug/DMA loader.
- Each request is latched, driven onto the memory for exactly one cycle, and acknowledged with registered read data.
- Round-robin fairness applies on simultaneous requests.

Parameters:
- DATA_WIDTH, 32, data word width; must match DataMemory.
- ADDR_WIDTH, 5, word address width; must match DataMemory.

Ports:
- clk  input  1  rising-edge clock shared with DataMemory
- rst_n  input  1  asynchronous active-low reset
- Req0 / Req1  input  1  request from requester 0 / 1; held high until Ack
- We0 / We1  input  1  1=write, 0=read; stable while Req high
- Addr0 / Addr1  input  ADDR_WIDTH  word address; stable while Req high
- WData0 / WData1  input  DATA_WIDTH  write data; stable while Req high
- Ack0 / Ack1  output  1  one-cycle completion pulse
- RData0 / RData1  output  DATA_WIDTH  read result; valid with Ack, held until the next read for that requester
- Busy  output  1  high whenever the FSM is not IDLE
- MemWriteEn  output  1  to DataMemory WriteEn
- MemReadEn  output  1  to DataMemory ReadEn
- MemAddress  output  ADDR_WIDTH  to DataMemory Address
- MemWriteData  output  DATA_WIDTH  to DataMemory WriteData
- MemReadData  input  DATA_WIDTH  from DataMemory ReadData; high-Z when MemReadEn=0

Behaviour:
- Clock/reset: one clock domain (clk); rst_n is asynchronous, active-low.
- Reset values:
  - State=IDLE; LastGnt=1, so requester 0 wins the first tie.
  - Ack0=Ack1=0, Busy=0, MemWriteEn=MemReadEn=0.
  - MemAddress=0, MemWriteData=0, RData0=RData1=0.
- FSM states: IDLE, SERVE, ACK.
- IDLE:
  - Sample Req0/Req1 at the edge.
  - Exactly one high: grant it.
  - Both high: grant the requester != LastGnt.
  - On grant: latch Gnt, We, Addr and WData into issue registers; go to SERVE; LastGnt<=Gnt.
  - No request: stay in IDLE.
- SERVE (one cycle):
  - MemAddress and MemWriteData come from the issue registers.
  - MemWriteEn=We_latched; MemReadEn=!We_latched.
  - Exactly one enable is high; both are low in every other state.
  - At the closing edge a write commits in DataMemory.
  - For a read, MemReadData is captured into RData[Gnt]; the other RData is unchanged.
  - Go to ACK.
- ACK (one cycle):
  - Ack[Gnt]=1, registered, so it is glitch-free; the other Ack stays 0.
  - Go to IDLE unconditionally.
- Latency: Req sampled at edge E0 → memory access in the cycle after E0 → Ack high in the cycle after E1 → IDLE after E2. Peak throughput is one access per 3 cycles.
- Requester contract:
  - Drop Req on the edge that samples Ack.
  - A Req still high when IDLE samples it is treated as a new request.
- Req/We/Addr/WData changes during SERVE or ACK are ignored; only the issue registers drive the memory.
- MemReadData is never captured outside SERVE with MemReadEn=1, so high-Z is never latched.
- Address is used modulo 2**ADDR_WIDTH; no range checking.
- Busy=1 in SERVE and ACK.
- The losing requester waits with Req high; it is guaranteed service at the next IDLE sample, so worst-case wait is 3 cycles.
- Reset mid-operation:
  - Async reset drops MemWriteEn immediately; a write in SERVE is not committed if rst_n falls before the SERVE closing edge.
  - No Ack is issued for the abandoned transaction; LastGnt returns to 1.
- Fully synthesizable; no latches; no combinational path from Req/Addr inputs to memory outputs.

Test Plan:
- Reset, then Req0=1, We0=0, Addr0=5 (memory preloaded dmem[i]=i) → MemReadEn=1 with MemAddress=5 for one cycle; Ack0 pulses 2 cycles after the request edge; RData0=32'd5; Ack1 stays 0.
- Req1=1, We1=1, Addr1=3, WData1=32'hDEADBEEF, then Req1 read of Addr1=3 → MemWriteEn high exactly one cycle; the second access returns RData1=32'hDEADBEEF; RData0 is unchanged.
- Req0 and Req1 both held high from reset, reads of addresses 1 and 2 → grant order 0,1,0,1; each Ack is 3 cycles apart; RData0=1, RData1=2; never two Acks in the same cycle.
- During SERVE, change Addr0 from 7 to 9 and drop Req0 → MemAddress stays 7 and Ack0 still issues; RData0=7.
- Assert rst_n=0 mid-SERVE of a write of 32'h12345678 to address 4 → MemWriteEn falls immediately; dmem[4] remains 4; no Ack; all outputs at reset values; the next Req1 tie with Req0 grants 0 first.
- Idle bus with Req0=Req1=0 for 10 cycles → Busy=0, MemReadEn=MemWriteEn=0 throughout; RData is never X/Z after the first read.
